// File: rtl/fetch_pc_unit_pkg.sv
// Shared constants and types for the instruction-fetch stage.
package fetch_pc_unit_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] NOP_INSTR        = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_INCR          = 32'd4;

  // Next-PC source select; HOLD covers the stalled cycle.
  typedef enum logic [1:0] {
    SEL_SEQ    = 2'd0,
    SEL_HOLD   = 2'd1,
    SEL_JUMP   = 2'd2,
    SEL_BRANCH = 2'd3
  } pc_sel_e;

  // IF/ID pipeline register payload.
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc_add;
    logic            valid;
  } if_id_t;

  // Redirect targets are always word aligned.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_pc_unit_if_id_reg.sv
// IF/ID pipeline register with hold and flush controls.
module if_id_reg
  import fetch_pc_unit_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   hold,
  input  logic   flush,
  input  if_id_t d,
  output if_id_t q
);

  // Reset beats hold, hold beats flush, flush inserts a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '{instr: NOP_INSTR, pc_add: '0, valid: 1'b0};
    end else if (hold) begin
      q <= q;
    end else if (flush) begin
      q <= '{instr: NOP_INSTR, pc_add: '0, valid: 1'b0};
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/fetch_pc_unit.sv
// Instruction-fetch stage: PC register, next-PC select and IF/ID register.
// Build option: DELAY_SLOT_EN keeps the instruction fetched in the redirect
// cycle (branch delay slot) instead of squashing it.
module fetch_pc_unit
  import fetch_pc_unit_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Stall,
  input  logic            Jump,
  input  logic [XLEN-1:0] JumpAddress,
  input  logic            Branch,
  input  logic [XLEN-1:0] BranchAddress,
  input  logic [XLEN-1:0] Instruction,
  output logic [XLEN-1:0] PCResult,
  output logic [XLEN-1:0] IF_ID_Instruction,
  output logic [XLEN-1:0] IF_ID_PCAddResult,
  output logic            IF_ID_Valid
);

  logic [XLEN-1:0] pc_add;
  logic [XLEN-1:0] pc_next;
  pc_sel_e         pc_sel;
  logic            redirect;
  logic            flush;
  if_id_t          if_id_d;
  if_id_t          if_id_q;

  assign pc_add = PCResult + PC_INCR;

  // Source priority: stall, then jump, then branch, then sequential.
  always_comb begin
    pc_sel = SEL_SEQ;
    if (Stall) begin
      pc_sel = SEL_HOLD;
    end else if (Jump) begin
      pc_sel = SEL_JUMP;
    end else if (Branch) begin
      pc_sel = SEL_BRANCH;
    end
  end

  // Next-PC mux; redirect targets get their low bits cleared.
  always_comb begin
    pc_next  = pc_add;
    redirect = 1'b0;
    case (pc_sel)
      SEL_HOLD:   pc_next = PCResult;
      SEL_JUMP: begin
        pc_next  = align_word(JumpAddress);
        redirect = 1'b1;
      end
      SEL_BRANCH: begin
        pc_next  = align_word(BranchAddress);
        redirect = 1'b1;
      end
      default:    pc_next = pc_add;
    endcase
  end

  // Program counter register.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      PCResult <= RESET_PC;
    end else begin
      PCResult <= pc_next;
    end
  end

`ifdef DELAY_SLOT_EN
  assign flush = 1'b0;
`else
  assign flush = redirect;
`endif

  assign if_id_d = '{instr: Instruction, pc_add: pc_add, valid: 1'b1};

  if_id_reg u_if_id_reg (
    .clk   (Clk),
    .reset (Reset),
    .hold  (Stall),
    .flush (flush),
    .d     (if_id_d),
    .q     (if_id_q)
  );

  assign IF_ID_Instruction = if_id_q.instr;
  assign IF_ID_PCAddResult = if_id_q.pc_add;
  assign IF_ID_Valid       = if_id_q.valid;

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Scoreboard bench for fetch_pc_unit: directed steps push expected state,
// a monitor pops and compares one entry after each rising edge.
module tb_fetch_pc_unit;

`ifdef DELAY_SLOT_EN
  localparam bit DS = 1'b1;
`else
  localparam bit DS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        jump = 1'b0;
  logic [31:0] jump_address = '0;
  logic        branch = 1'b0;
  logic [31:0] branch_address = '0;
  logic [31:0] instruction = '0;
  logic [31:0] pc_result;
  logic [31:0] if_id_instruction;
  logic [31:0] if_id_pc_add_result;
  logic        if_id_valid;

  typedef struct {
    string       name;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc_add;
    logic        valid;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  fetch_pc_unit dut (
    .Clk               (clk),
    .Reset             (reset),
    .Stall             (stall),
    .Jump              (jump),
    .JumpAddress       (jump_address),
    .Branch            (branch),
    .BranchAddress     (branch_address),
    .Instruction       (instruction),
    .PCResult          (pc_result),
    .IF_ID_Instruction (if_id_instruction),
    .IF_ID_PCAddResult (if_id_pc_add_result),
    .IF_ID_Valid       (if_id_valid)
  );

  task automatic cmp(input string name, input string field,
                     input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s.%s actual=%h required=%h", name, field, act, req);
    end
  endtask

  // Monitor: the DUT presents a new IF state after every rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      cmp(e.name, "pc",     pc_result,           e.pc);
      cmp(e.name, "instr",  if_id_instruction,   e.instr);
      cmp(e.name, "pcadd",  if_id_pc_add_result, e.pc_add);
      cmp(e.name, "valid",  {31'd0, if_id_valid}, {31'd0, e.valid});
    end
  end

  // Drive one cycle of inputs and queue the state expected after the edge.
  task automatic step(input string name, input logic rst, input logic stl,
                      input logic jmp, input logic [31:0] ja,
                      input logic br, input logic [31:0] ba,
                      input logic [31:0] ins,
                      input logic [31:0] e_pc, input logic [31:0] e_instr,
                      input logic [31:0] e_pa, input logic e_v);
    exp_t e;
    @(negedge clk);
    reset = rst; stall = stl; jump = jmp; jump_address = ja;
    branch = br; branch_address = ba; instruction = ins;
    e.name = name; e.pc = e_pc; e.instr = e_instr; e.pc_add = e_pa; e.valid = e_v;
    sb.push_back(e);
  endtask

  localparam logic [31:0] I0 = 32'h2008_0005, I1 = 32'h2009_0007,
                          I2 = 32'h1111_0008, I3 = 32'h2222_0020,
                          I4 = 32'h4444_0024, I5 = 32'h5555_0100,
                          I6 = 32'h6666_0200, I7 = 32'h7777_0010,
                          I8 = 32'h8888_1000, I9 = 32'h9999_FFFC,
                          IA = 32'hAAAA_0000, IB = 32'hBBBB_0004,
                          IC = 32'hCCCC_0000;

  logic [31:0] h_instr;
  logic [31:0] h_pa;
  logic        h_v;

  initial begin
    int budget;
    step("reset0", 1, 0, 0, 0, 0, 0, I0, 32'h0, 0, 0, 0);
    step("reset1", 1, 0, 0, 0, 0, 0, I0, 32'h0, 0, 0, 0);
    step("seq0",   0, 0, 0, 0, 0, 0, I0, 32'h4, I0, 32'h4, 1);
    step("seq4",   0, 0, 0, 0, 0, 0, I1, 32'h8, I1, 32'h8, 1);
    step("jump8",  0, 0, 1, 32'h0040_0020, 0, 0, I2, 32'h0040_0020,
         DS ? I2 : 32'h0, DS ? 32'hC : 32'h0, DS);
    step("jtgt",   0, 0, 0, 0, 0, 0, I3, 32'h0040_0024, I3, 32'h0040_0024, 1);
    step("jprio",  0, 0, 1, 32'h100, 1, 32'h200, I4, 32'h100,
         DS ? I4 : 32'h0, DS ? 32'h0040_0028 : 32'h0, DS);
    step("bralign", 0, 0, 0, 0, 1, 32'h203, I5, 32'h200,
         DS ? I5 : 32'h0, DS ? 32'h104 : 32'h0, DS);
    step("to10",   0, 0, 1, 32'h10, 0, 0, I6, 32'h10,
         DS ? I6 : 32'h0, DS ? 32'h204 : 32'h0, DS);
    h_instr = DS ? I6 : 32'h0;
    h_pa    = DS ? 32'h204 : 32'h0;
    h_v     = DS;
    for (int i = 0; i < 3; i++)
      step("stall", 0, 1, 1, 32'h1000, 0, 0, I7, 32'h10, h_instr, h_pa, h_v);
    step("unstall", 0, 0, 1, 32'h1000, 0, 0, I7, 32'h1000,
         DS ? I7 : 32'h0, DS ? 32'h14 : 32'h0, DS);
    step("jmisal", 0, 0, 1, 32'hFFFF_FFFE, 0, 0, I8, 32'hFFFF_FFFC,
         DS ? I8 : 32'h0, DS ? 32'h1004 : 32'h0, DS);
    step("wrap",   0, 0, 0, 0, 0, 0, I9, 32'h0, I9, 32'h0, 1);
    step("postwrap", 0, 0, 0, 0, 0, 0, IA, 32'h4, IA, 32'h4, 1);
    step("rstredir", 1, 0, 1, 32'h500, 0, 0, IB, 32'h0, 0, 0, 0);
    step("rstrel", 0, 0, 0, 0, 0, 0, IC, 32'h4, IC, 32'h4, 1);
    step("rststall", 1, 1, 0, 0, 0, 0, IC, 32'h0, 0, 0, 0);
    @(negedge clk);
    reset = 1'b0;
    budget = 10;
    while (sb.size() > 0 && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain pending=%0d required=0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Watchdog against a hung run.
  initial begin
    #100000;
    $display("FAIL watchdog time=%0t required=finish", $time);
    $fatal(1, "timeout");
  end

endmodule
